leaf_out_arbiter: RTL and testbench
===================================

Name: leaf_out_arbiter

Overview:
- Round-robin scheduler that shares one leaf_interface output port among NUM_REQ user output streams inside a page wrapper.
- Each requester uses the page's valid/ready stream convention (TDATA/TVALID/TREADY-equivalent), typically at PAYLOAD_BITS after width conversion.
- Grants are held for a bounded burst, so packets from one stream stay contiguous.
- Output is registered, and the block gates all traffic on ap_start.

Parameters:
NUM_REQ, 4, number of requesting streams (2..16)
REQ_BITS, 2, width of grant index, equal to ceil(log2(NUM_REQ))
PAYLOAD_BITS, 32, data width per stream
BURST_LEN, 16, maximum words transferred per grant (>=1)
IDLE_TIMEOUT, 4, consecutive cycles with granted vld_in low before the grant is released (>=1)

Ports:
clk  input  1  clock
reset  input  1  synchronous, active-high reset
ap_start  input  1  enables new grants; level-sensitive
din  input  NUM_REQ*PAYLOAD_BITS  requester data; slice i = din[i*PAYLOAD_BITS +: PAYLOAD_BITS]
vld_in  input  NUM_REQ  per-requester valid
rdy_upward  output  NUM_REQ  per-requester ready
dout  output  PAYLOAD_BITS  registered data toward leaf_interface
vld_out  output  1  registered valid toward leaf_interface
rdy_downward  input  1  ready from leaf_interface
grant_id  output  REQ_BITS  index of current or last granted requester
busy  output  1  high while in GRANT state

Behaviour:
- Clock, reset and conventions:
  - Single clock domain: clk.
  - reset is synchronous and active-high; all state is sampled on the rising edge of clk.
- Reset values: state=IDLE, rr_ptr=0, grant_id=0, busy=0, vld_out=0, dout=0, burst_cnt=0, idle_cnt=0, rdy_upward=0.
  - Reset asserted mid-burst drops the granted word and any word in the output register; no partial recovery.
- Output register (1-entry pipeline):
  - load_en = !vld_out || rdy_downward.
  - rdy_upward[i] = (state==GRANT) && (i==grant_id) && load_en. All other bits are 0.
  - accept = vld_in[grant_id] && rdy_upward[grant_id].
  - On accept: dout <= din slice of grant_id; vld_out <= 1.
  - Else, if rdy_downward: vld_out <= 0. dout holds its value.
  - Latency from accept to vld_out is 1 cycle. Sustained throughput is 1 word/cycle while rdy_downward is high.
  - dout must stay stable while vld_out=1 and rdy_downward=0.
- FSM:
  - IDLE:
    - If ap_start=1 and any vld_in bit is set, select the first set index scanning rr_ptr, rr_ptr+1, ..., wrapping modulo NUM_REQ.
    - grant_id <= selected index; burst_cnt <= 0; idle_cnt <= 0; go to GRANT.
    - Otherwise stay in IDLE.
    - IDLE never accepts data, so there is a 1-cycle arbitration bubble between grants.
  - GRANT:
    - On accept: burst_cnt++ and idle_cnt <= 0.
    - If vld_in[grant_id]=0: idle_cnt++.
    - If vld_in[grant_id]=1 but stalled by load_en=0: idle_cnt holds (backpressure is not idleness).
    - Release to IDLE next cycle when either:
      - accept occurs with burst_cnt==BURST_LEN-1, or
      - idle_cnt reaches IDLE_TIMEOUT-1 while vld_in[grant_id]=0.
    - On release: rr_ptr <= (grant_id+1) mod NUM_REQ, with explicit wrap for non-power-of-2 NUM_REQ.
    - grant_id holds its value in IDLE until the next grant.
- ap_start:
  - Deasserting ap_start during GRANT does not abort the burst; it only blocks the next grant.
  - The output register still drains while ap_start=0.
- Simultaneous events:
  - A release condition and reaching BURST_LEN in the same cycle produce a single release.
  - A requester dropping vld_in during backpressure is not legal stream behaviour. The block does not check for it.
- Counter widths:
  - burst_cnt is wide enough to hold BURST_LEN-1.
  - idle_cnt is wide enough to hold IDLE_TIMEOUT-1.
  - Both saturate-free, because the release logic bounds them.

Test Plan:
1. Requester 0 only, 20 words back-to-back, rdy_downward=1, BURST_LEN=16 -> 16 words out consecutively, 1-cycle bubble, re-grant to 0, 4 words, then idle release after 4 cycles with vld_in[0]=0; total 20 words in order.
2. All 4 requesters continuously valid, each word tagged with its requester id -> output bursts of 16 in order 0,1,2,3,0; grant_id matches tag; no word lost or duplicated.
3. Requester 2 streaming, rdy_downward toggled 1,0,0,1 repeatedly -> dout stable while stalled; idle_cnt stays 0; burst still ends at 16 accepted words; rdy_upward[2] low only when the output register is full and rdy_downward=0.
4. Requester 1 sends 3 words then drops valid while requester 3 is waiting -> release after 4 idle cycles, grant to 3 after the 1-cycle bubble, rr_ptr=2 at that grant.
5. ap_start=0 with vld_in=4'b1111 -> no grant, rdy_upward=0, vld_out=0. Then ap_start=1 -> grant to 0 within 1 cycle.
6. reset pulsed after 5 words of a burst -> next cycle: vld_out=0, busy=0, grant_id=0, rdy_upward=0. After reset drops, arbitration restarts from requester 0.

Source files
------------

// File: rtl/leaf_out_arbiter.sv
// Round-robin arbiter sharing one registered leaf_interface output among NUM_REQ
// valid/ready streams; grants last up to BURST_LEN words or until IDLE_TIMEOUT idle cycles.
module leaf_out_arbiter #(
    parameter int NUM_REQ      = 4,
    parameter int REQ_BITS     = 2,
    parameter int PAYLOAD_BITS = 32,
    parameter int BURST_LEN    = 16,
    parameter int IDLE_TIMEOUT = 4
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            ap_start,
    input  logic [NUM_REQ*PAYLOAD_BITS-1:0] din,
    input  logic [NUM_REQ-1:0]              vld_in,
    output logic [NUM_REQ-1:0]              rdy_upward,
    output logic [PAYLOAD_BITS-1:0]         dout,
    output logic                            vld_out,
    input  logic                            rdy_downward,
    output logic [REQ_BITS-1:0]             grant_id,
    output logic                            busy
);
    localparam int BW = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
    localparam int IW = (IDLE_TIMEOUT > 1) ? $clog2(IDLE_TIMEOUT) : 1;
    localparam logic [BW-1:0]       BURST_LAST = BW'(BURST_LEN - 1);
    localparam logic [IW-1:0]       IDLE_LAST  = IW'(IDLE_TIMEOUT - 1);
    localparam logic [REQ_BITS-1:0] LAST_REQ   = REQ_BITS'(NUM_REQ - 1);
    localparam logic [REQ_BITS:0]   NUM_REQ_W  = (REQ_BITS + 1)'(NUM_REQ);

    typedef enum logic {IDLE, GRANT} state_t;

    state_t                    state_q, state_d;
    logic [REQ_BITS-1:0]       grant_q, grant_d;
    logic [REQ_BITS-1:0]       rr_ptr_q, rr_ptr_d;
    logic [BW-1:0]             burst_cnt_q, burst_cnt_d;
    logic [IW-1:0]             idle_cnt_q, idle_cnt_d;
    logic [PAYLOAD_BITS-1:0]   dout_q, dout_d;
    logic                      vld_out_q, vld_out_d;

    logic                      load_en, accept, sel_vld;
    logic [PAYLOAD_BITS-1:0]   sel_data;
    logic [NUM_REQ-1:0]        vld_rot;
    logic [REQ_BITS:0]         pick_sum;
    logic [REQ_BITS-1:0]       pick_idx, rr_after;

    always_comb begin
        sel_vld  = 1'b0;
        sel_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_q == REQ_BITS'(i)) begin
                sel_vld  = vld_in[i];
                sel_data = din[i*PAYLOAD_BITS +: PAYLOAD_BITS];
            end
        end
    end

    assign load_en = !vld_out_q || rdy_downward;
    assign accept  = (state_q == GRANT) && load_en && sel_vld;

    always_comb begin
        rdy_upward = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            rdy_upward[i] = (state_q == GRANT) && load_en && (grant_q == REQ_BITS'(i));
        end
    end

    // Rotate requests so bit 0 is rr_ptr; the lowest set bit is the next winner.
    always_comb begin
        vld_rot  = NUM_REQ'({vld_in, vld_in} >> rr_ptr_q);
        pick_sum = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (vld_rot[k]) pick_sum = {1'b0, rr_ptr_q} + (REQ_BITS + 1)'(k);
        end
        if (pick_sum >= NUM_REQ_W) pick_sum = pick_sum - NUM_REQ_W;
        pick_idx = pick_sum[REQ_BITS-1:0];
    end

    assign rr_after = (grant_q == LAST_REQ) ? '0 : grant_q + 1'b1;

    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        rr_ptr_d    = rr_ptr_q;
        burst_cnt_d = burst_cnt_q;
        idle_cnt_d  = idle_cnt_q;
        dout_d      = dout_q;
        vld_out_d   = vld_out_q;

        if (accept) begin
            dout_d    = sel_data;
            vld_out_d = 1'b1;
        end else if (rdy_downward) begin
            vld_out_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (ap_start && (|vld_in)) begin
                    state_d     = GRANT;
                    grant_d     = pick_idx;
                    burst_cnt_d = '0;
                    idle_cnt_d  = '0;
                end
            end
            GRANT: begin
                if (accept) begin
                    idle_cnt_d = '0;
                    if (burst_cnt_q == BURST_LAST) begin
                        state_d  = IDLE;
                        rr_ptr_d = rr_after;
                    end else begin
                        burst_cnt_d = burst_cnt_q + 1'b1;
                    end
                end else if (!sel_vld) begin
                    if (idle_cnt_q == IDLE_LAST) begin
                        state_d  = IDLE;
                        rr_ptr_d = rr_after;
                    end else begin
                        idle_cnt_d = idle_cnt_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            grant_q     <= '0;
            rr_ptr_q    <= '0;
            burst_cnt_q <= '0;
            idle_cnt_q  <= '0;
            dout_q      <= '0;
            vld_out_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            rr_ptr_q    <= rr_ptr_d;
            burst_cnt_q <= burst_cnt_d;
            idle_cnt_q  <= idle_cnt_d;
            dout_q      <= dout_d;
            vld_out_q   <= vld_out_d;
        end
    end

    assign dout     = dout_q;
    assign vld_out  = vld_out_q;
    assign grant_id = grant_q;
    assign busy     = (state_q == GRANT);
endmodule

// File: tb/tb_leaf_out_arbiter.sv
// Randomized scoreboard bench for leaf_out_arbiter: a transaction-level grant model
// predicts accepted words into a queue; a separate monitor checks them at the output.
module tb_leaf_out_arbiter;
    localparam int N  = 4;
    localparam int RB = 2;
    localparam int PB = 32;
    localparam int B  = 16;
    localparam int T  = 4;

    logic              clk = 1'b0;
    logic              reset;
    logic              ap_start;
    logic [N*PB-1:0]   din;
    logic [N-1:0]      vld_in;
    logic [N-1:0]      rdy_upward;
    logic [PB-1:0]     dout;
    logic              vld_out;
    logic              rdy_downward;
    logic [RB-1:0]     grant_id;
    logic              busy;

    leaf_out_arbiter #(
        .NUM_REQ(N), .REQ_BITS(RB), .PAYLOAD_BITS(PB), .BURST_LEN(B), .IDLE_TIMEOUT(T)
    ) dut (
        .clk(clk), .reset(reset), .ap_start(ap_start), .din(din), .vld_in(vld_in),
        .rdy_upward(rdy_upward), .dout(dout), .vld_out(vld_out),
        .rdy_downward(rdy_downward), .grant_id(grant_id), .busy(busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int fails  = 0;

    // stimulus sources
    int seq[N];
    int remaining[N];
    bit presenting[N];
    bit hs[N];
    int k_mask, p_present, p_rdy, p_ap, p_reset;

    // reference model: owner of the port, words it has sent, idle cycles seen
    bit m_busy, m_vo;
    int m_owner, m_rr, m_words, m_idle, m_grant;
    logic [PB-1:0] exp_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic model_release();
        m_busy = 0;
        m_rr   = (m_owner + 1) % N;
    endtask

    task automatic model_step();
        bit load, acc;
        logic [31:0] exp_rdy;
        load    = !m_vo || rdy_downward;
        exp_rdy = (m_busy && load) ? (32'd1 << m_owner) : 32'd0;
        chk("rdy_upward", 32'(rdy_upward), exp_rdy);
        chk("busy", 32'(busy), 32'(m_busy));
        chk("grant_id", 32'(grant_id), 32'(m_grant));
        chk("vld_out", 32'(vld_out), 32'(m_vo));
        if (reset) begin
            m_busy = 0; m_vo = 0; m_rr = 0; m_grant = 0; m_owner = 0;
            return;
        end
        if (m_busy) begin
            acc = vld_in[m_owner] && load;
            if (acc) begin
                exp_q.push_back(din[m_owner*PB +: PB]);
                m_vo = 1;
                m_words++;
                m_idle = 0;
                if (m_words == B) model_release();
            end else begin
                if (rdy_downward) m_vo = 0;
                if (!vld_in[m_owner]) begin
                    m_idle++;
                    if (m_idle == T) model_release();
                end
            end
        end else begin
            if (rdy_downward) m_vo = 0;
            if (ap_start && vld_in != '0) begin
                for (int k = 0; k < N; k++) begin
                    if (!m_busy && vld_in[(m_rr + k) % N]) begin
                        m_owner = (m_rr + k) % N;
                        m_busy  = 1;
                    end
                end
                m_grant = m_owner;
                m_words = 0;
                m_idle  = 0;
            end
        end
    endtask

    task automatic run_cycle();
        @(negedge clk);
        for (int i = 0; i < N; i++) begin
            if (hs[i]) begin
                seq[i]++;
                remaining[i]--;
                presenting[i] = 0;
            end
            if (!presenting[i] && remaining[i] > 0 && k_mask[i] && $urandom_range(99) < p_present)
                presenting[i] = 1;
            vld_in[i] = presenting[i];
            din[i*PB +: PB] = {8'(i), 24'(seq[i])};
        end
        rdy_downward = ($urandom_range(99) < p_rdy);
        ap_start     = ($urandom_range(99) < p_ap);
        reset        = ($urandom_range(99) < p_reset);
        #1;
        model_step();
        for (int i = 0; i < N; i++) hs[i] = vld_in[i] && rdy_upward[i];
        if (reset) begin
            #2;
            exp_q.delete();
        end
    endtask

    task automatic new_phase(input int mask, input int words, input int pp, input int pr,
                             input int pa, input int prst);
        k_mask = mask; p_present = pp; p_rdy = pr; p_ap = pa; p_reset = prst;
        for (int i = 0; i < N; i++) remaining[i] = mask[i] ? words : 0;
    endtask

    task automatic drain(input string name);
        bit done, any_pres;
        done = 0;
        p_present = 0; p_rdy = 100; p_ap = 100; p_reset = 0;
        for (int c = 0; c < 300 && !done; c++) begin
            run_cycle();
            any_pres = 0;
            for (int i = 0; i < N; i++) any_pres |= presenting[i];
            done = !m_busy && !m_vo && exp_q.size() == 0 && !any_pres;
        end
        checks++;
        if (!done) begin
            fails++;
            $display("FAIL drain_%s: got outstanding %0d words expected 0 within 300 cycles", name, exp_q.size());
        end
    endtask

    always @(negedge clk) begin
        #2;
        if (vld_out === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                fails++;
                $display("FAIL dout_unexpected at %0t: got %0h expected no word", $time, dout);
            end else begin
                chk("dout", dout, exp_q[0]);
                if (rdy_downward) void'(exp_q.pop_front());
            end
        end
    end

    initial begin
        reset = 1'b1; ap_start = 1'b0; rdy_downward = 1'b0; vld_in = '0; din = '0;
        for (int i = 0; i < N; i++) begin
            seq[i] = 0; remaining[i] = 0; presenting[i] = 0; hs[i] = 0;
        end
        m_busy = 0; m_vo = 0; m_owner = 0; m_rr = 0; m_words = 0; m_idle = 0; m_grant = 0;

        new_phase(0, 0, 0, 100, 0, 100);
        repeat (3) run_cycle();

        // single requester, 20 words: burst of 16, bubble, 4 more, idle release
        new_phase(4'b0001, 20, 100, 100, 100, 0);
        repeat (60) run_cycle();
        drain("single");

        // everyone saturating: bursts rotate 0,1,2,3,0
        new_phase(4'b1111, 40, 100, 100, 100, 0);
        repeat (100) run_cycle();
        drain("all");

        // requester 2 under downstream backpressure
        new_phase(4'b0100, 40, 100, 50, 100, 0);
        repeat (80) run_cycle();
        drain("backpressure");

        // ap_start held low with all valid, then released
        new_phase(4'b1111, 5, 100, 100, 0, 0);
        repeat (10) run_cycle();
        p_ap = 100;
        repeat (30) run_cycle();
        drain("ap_start");

        // sparse requests: idle timeouts and handoffs to waiting requesters
        new_phase(4'b1111, 200, 30, 80, 100, 0);
        repeat (600) run_cycle();
        drain("sparse");

        // everything random including mid-burst resets
        new_phase(4'b1111, 1000, 60, 70, 90, 2);
        repeat (3000) run_cycle();
        drain("random");

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end
endmodule
